// File: rtl/jtag_user_pkg.sv
// Shared op codes, FSM state type and DR width helper for the JTAG USER1 bus master.
package jtag_user_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic int unsigned dr_w(input int unsigned addr_w, input int unsigned data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Oversamples the BSCANE2 outputs into clk_p and derives TCK and UPDATE edge strobes.
module jtag_tap_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_p,
    input  logic rst_n,
    input  logic tck,
    input  logic tdi,
    input  logic sel,
    input  logic shift,
    input  logic capture,
    input  logic update,
    input  logic reset,
    output logic tdi_s,
    output logic sel_s,
    output logic shift_s,
    output logic capture_s,
    output logic reset_s,
    output logic tck_rise,
    output logic tck_fall,
    output logic update_rise
);

    // bit map: 0 tck, 1 tdi, 2 sel, 3 shift, 4 capture, 5 update, 6 reset
    logic [SYNC_STAGES-1:0][6:0] stage;
    logic [6:0]                  last;
    logic                        tck_d;
    logic                        update_d;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            stage       <= '0;
            tck_d       <= 1'b0;
            update_d    <= 1'b0;
            update_rise <= 1'b0;
        end else begin
            stage       <= {stage[SYNC_STAGES-2:0], {reset, update, capture, shift, sel, tdi, tck}};
            tck_d       <= last[0];
            update_d    <= last[5];
            // registered so the decode lands one cycle after the synced edge
            update_rise <= last[5] & ~update_d;
        end
    end

    assign last      = stage[SYNC_STAGES-1];
    assign tdi_s     = last[1];
    assign sel_s     = last[2];
    assign shift_s   = last[3];
    assign capture_s = last[4];
    assign reset_s   = last[6];
    assign tck_rise  = last[0] & ~tck_d;
    assign tck_fall  = ~last[0] & tck_d;

endmodule

// File: rtl/jtag_user_ctrl.sv
// BSCANE2 USER1 data register turned into a single-outstanding req/ack bus master.
module jtag_user_ctrl
    import jtag_user_pkg::*;
#(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_p,
    input  logic              rst_top,
    input  logic              TCK,
    input  logic              TDI,
    input  logic              SEL,
    input  logic              SHIFT,
    input  logic              CAPTURE,
    input  logic              UPDATE,
    input  logic              RESET,
    output logic              TDO,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              err
);

    localparam int unsigned      DR_W     = dr_w(ADDR_W, DATA_W);
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic tdi_s, sel_s, shift_s, capture_s, reset_s;
    logic tck_rise, tck_fall, update_rise;

    jtag_tap_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_p      (clk_p),
        .rst_n      (rst_top),
        .tck        (TCK),
        .tdi        (TDI),
        .sel        (SEL),
        .shift      (SHIFT),
        .capture    (CAPTURE),
        .update     (UPDATE),
        .reset      (RESET),
        .tdi_s      (tdi_s),
        .sel_s      (sel_s),
        .shift_s    (shift_s),
        .capture_s  (capture_s),
        .reset_s    (reset_s),
        .tck_rise   (tck_rise),
        .tck_fall   (tck_fall),
        .update_rise(update_rise)
    );

    state_t            state;
    logic [DR_W-1:0]   sr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_rdata;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_valid, cmd_rw;
    logic              start, overrun, clear, ack_hit, timeout;

    assign cmd_op    = sr[DR_W-1 -: 2];
    assign cmd_addr  = sr[DATA_W +: ADDR_W];
    assign cmd_data  = sr[DATA_W-1:0];
    assign cmd_valid = update_rise & sel_s & ~reset_s;
    assign cmd_rw    = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
    assign start     = cmd_valid & cmd_rw & (state == IDLE);
    assign overrun   = cmd_valid & cmd_rw & (state != IDLE);
    assign clear     = cmd_valid & (cmd_op == OP_CLEAR);
    assign ack_hit   = (state == REQ) & bus_ack;
    assign timeout   = (state == REQ) & ~bus_ack & (cnt == CNT_LAST);

    always_ff @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            sr  <= '0;
            TDO <= 1'b0;
        end else if (reset_s) begin
            sr  <= '0;
            TDO <= 1'b0;
        end else if (sel_s) begin
            if (tck_rise && capture_s)
                sr <= {busy, err, last_addr, last_rdata};
            else if (tck_rise && shift_s)
                sr <= {tdi_s, sr[DR_W-1:1]};
            if (tck_fall && shift_s)
                TDO <= sr[0];
        end
    end

    // TAP reset leaves the FSM alone so an in-flight transaction still completes
    always_ff @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        bus_req   <= 1'b1;
                        busy      <= 1'b1;
                        bus_we    <= (cmd_op == OP_WRITE);
                        bus_addr  <= cmd_addr;
                        bus_wdata <= cmd_data;
                        cnt       <= '0;
                    end else if (reset_s) begin
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack || cnt == CNT_LAST) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            err        <= 1'b0;
            last_addr  <= '0;
            last_rdata <= '0;
        end else if (reset_s) begin
            err        <= 1'b0;
            last_addr  <= '0;
            last_rdata <= '0;
        end else begin
            if (overrun || timeout)
                err <= 1'b1;
            else if (clear)
                err <= 1'b0;
            if (start)
                last_addr <= cmd_addr;
            if (ack_hit && !bus_we)
                last_rdata <= bus_rdata;
            else if (timeout)
                last_rdata <= '1;
        end
    end

endmodule

// File: tb/tb_jtag_user_ctrl.sv
// Randomised bench for jtag_user_ctrl: drives TAP sequences and checks against a command-level model.
module tb_jtag_user_ctrl;
    import jtag_user_pkg::*;

    localparam int unsigned AW   = 30;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 64;
    localparam int unsigned SS   = 2;
    localparam int unsigned DRW  = 2 + AW + DW;
    localparam int          HALF = 6;

    logic          clk_p = 1'b0;
    logic          rst_top;
    logic          TCK, TDI, SEL, SHIFT, CAPTURE, UPDATE, RESET;
    logic          TDO;
    logic          bus_req, bus_we, bus_ack, busy, err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;

    int checks   = 0;
    int failures = 0;

    logic          m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata;

    jtag_user_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_p    (clk_p),
        .rst_top  (rst_top),
        .TCK      (TCK),
        .TDI      (TDI),
        .SEL      (SEL),
        .SHIFT    (SHIFT),
        .CAPTURE  (CAPTURE),
        .UPDATE   (UPDATE),
        .RESET    (RESET),
        .TDO      (TDO),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_p);
    endtask

    // Shifts n bits of din LSB first; dout collects the first DRW bits seen on TDO.
    task automatic scan(input logic [2*DRW-1:0] din, input int n, input bit cap,
                        output logic [DRW-1:0] dout);
        dout = '0;
        if (cap) CAPTURE = 1'b1;
        wait_clk(HALF);
        TCK = 1'b1;
        wait_clk(HALF);
        CAPTURE = 1'b0;
        SHIFT   = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) begin
            TCK = 1'b0;
            wait_clk(HALF);
            if (i < int'(DRW)) dout[i] = TDO;
            TDI = din[i];
            TCK = 1'b1;
            wait_clk(HALF);
        end
        SHIFT = 1'b0;
        wait_clk(HALF);
        TCK = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DRW-1:0] junk;
        scan({{DRW{1'b0}}, op, a, d}, DRW, 1'b0, junk);
    endtask

    task automatic upd_go(output int lat);
        lat    = 0;
        UPDATE = 1'b1;
        while (!bus_req && lat < 40) begin
            @(negedge clk_p);
            lat++;
        end
        UPDATE = 1'b0;
    endtask

    task automatic upd_pulse();
        UPDATE = 1'b1;
        wait_clk(SS + 3);
        UPDATE = 1'b0;
        wait_clk(SS + 3);
    endtask

    // Bus responder: acks in REQ cycle dly (never if dly >= TO); hi = cycles bus_req was seen high.
    task automatic serve(input int dly, input logic [DW-1:0] rd, output int hi);
        int            guard;
        bit            stable;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          we0;
        guard  = 0;
        hi     = 0;
        stable = 1'b1;
        while (!bus_req && guard < 100) begin
            @(negedge clk_p);
            guard++;
        end
        a0  = bus_addr;
        d0  = bus_wdata;
        we0 = bus_we;
        while (bus_req && hi < int'(TO) + 8) begin
            if (bus_addr !== a0 || bus_wdata !== d0 || bus_we !== we0 || busy !== 1'b1) stable = 1'b0;
            bus_ack   = (hi == dly);
            bus_rdata = (hi == dly) ? rd : DW'($urandom);
            hi++;
            @(negedge clk_p);
        end
        bus_ack = 1'b0;
        chk("req_stable", stable, 1);
    endtask

    function automatic int model_txn(input logic [1:0] op, input logic [AW-1:0] a,
                                     input int dly, input logic [DW-1:0] rd);
        m_addr = a;
        if (dly < int'(TO)) begin
            if (op == OP_READ) m_rdata = rd;
            return dly + 1;
        end
        m_err   = 1'b1;
        m_rdata = '1;
        return TO;
    endfunction

    task automatic do_rw(input string tg, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int dly, input logic [DW-1:0] rd);
        int lat, hi, exp_hi;
        send(op, a, d);
        upd_go(lat);
        chk({tg, "_lat"}, lat, SS + 2);
        chk({tg, "_we"}, bus_we, op == OP_WRITE);
        chk({tg, "_addr"}, bus_addr, a);
        chk({tg, "_wdata"}, bus_wdata, d);
        serve(dly, rd, hi);
        exp_hi = model_txn(op, a, dly, rd);
        chk({tg, "_hi"}, hi, exp_hi);
        chk({tg, "_err"}, err, m_err);
        chk({tg, "_idle"}, {bus_req, busy}, 2'b00);
    endtask

    task automatic readback(input string tg, input logic [2*DRW-1:0] din);
        logic [DRW-1:0] dout;
        scan(din, DRW, 1'b1, dout);
        chk(tg, dout, {1'b0, m_err, m_addr, m_rdata});
    endtask

    initial begin
        logic [1:0]     op;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d, rd;
        logic [DRW-1:0] dout;
        logic [63:0]    cmd;
        logic [6:0]     junk;
        int             lat, hi, r, dly, extra;

        rst_top = 1'b0;
        {TCK, TDI, SEL, SHIFT, CAPTURE, UPDATE, RESET} = '0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        m_err = 1'b0;
        m_addr = '0;
        m_rdata = '0;
        wait_clk(5);
        chk("rst_outs", {bus_req, busy, err, TDO, bus_we}, 5'b0);
        chk("rst_bus", {bus_addr, bus_wdata}, '0);
        rst_top = 1'b1;
        SEL = 1'b1;
        wait_clk(5);
        readback("rst_rb", {$urandom, $urandom, $urandom, $urandom});

        do_rw("wr", OP_WRITE, 30'h10, 32'hDEADBEEF, 3, 32'h0);
        do_rw("rd", OP_READ, 30'h20, 32'h0, 1, 32'h12345678);
        readback("rd_rb", {$urandom, $urandom, $urandom, $urandom});
        do_rw("to", OP_READ, 30'h30, 32'h0, TO + 50, 32'h0);
        readback("to_rb", {$urandom, $urandom, $urandom, $urandom});

        send(OP_CLEAR, '0, '0);
        upd_pulse();
        m_err = 1'b0;
        chk("clr0_err", err, 0);
        send(OP_WRITE, 30'h44, 32'hCAFEF00D);
        upd_go(lat);
        wait_clk(SS + 3);
        upd_pulse();
        m_err = 1'b1;
        chk("ovr_busy", busy, 1);
        chk("ovr_err", err, 1);
        serve(0, 32'h0, hi);
        void'(model_txn(OP_WRITE, 30'h44, 0, 32'h0));
        extra = 0;
        repeat (30) begin
            @(negedge clk_p);
            if (bus_req) extra++;
        end
        chk("ovr_extra", extra, 0);
        send(OP_CLEAR, '0, '0);
        upd_pulse();
        m_err = 1'b0;
        chk("clr1_err", err, 0);

        do_rw("edge", OP_READ, 30'h40, 32'h0, TO - 1, 32'hA5A55A5A);
        readback("edge_rb", {$urandom, $urandom, $urandom, $urandom});

        cmd  = {OP_WRITE, 30'h155, 32'h0BADF00D};
        junk = 7'($urandom);
        scan({57'b0, cmd, junk}, DRW + 7, 1'b0, dout);
        upd_go(lat);
        chk("wrap_addr", bus_addr, 30'h155);
        chk("wrap_wdata", bus_wdata, 32'h0BADF00D);
        chk("wrap_we", bus_we, 1);
        serve(2, 32'h0, hi);
        void'(model_txn(OP_WRITE, 30'h155, 2, 32'h0));

        for (int it = 0; it < 10; it++) begin
            op = 2'($urandom_range(0, 3));
            a  = AW'($urandom);
            d  = $urandom;
            rd = $urandom;
            r  = $urandom_range(0, 9);
            dly = (r < 7) ? r : ((r == 7) ? int'(TO) - 1 : int'(TO) + 50);
            if (op == OP_READ || op == OP_WRITE) begin
                do_rw("rnd", op, a, d, dly, rd);
            end else begin
                send(op, a, d);
                upd_pulse();
                if (op == OP_CLEAR) m_err = 1'b0;
                chk("rnd_noreq", bus_req, 0);
                chk("rnd_err", err, m_err);
                bus_ack   = 1'b1;
                bus_rdata = $urandom;
                @(negedge clk_p);
                bus_ack   = 1'b0;
            end
            readback("rnd_rb", {$urandom, $urandom, $urandom, $urandom});
        end

        do_rw("rto2", OP_READ, 30'h77, 32'h0, TO + 50, 32'h0);
        readback("rto2_rb", '1);
        send(OP_READ, 30'h78, 32'h1);
        upd_go(lat);
        chk("pre_tdo", TDO, 1);
        chk("pre_err", err, 1);
        chk("pre_busy", busy, 1);
        rst_top = 1'b0;
        #1;
        chk("async_rst", {bus_req, busy, err, TDO}, 4'b0);
        wait_clk(3);
        rst_top = 1'b1;
        m_err = 1'b0;
        m_addr = '0;
        m_rdata = '0;
        wait_clk(10);
        chk("post_rst_idle", {bus_req, busy}, 2'b00);
        readback("post_rst_rb", {$urandom, $urandom, $urandom, $urandom});

        send(OP_WRITE, 30'h99, 32'h5);
        upd_go(lat);
        wait_clk(SS + 3);
        upd_pulse();
        chk("tr_pre_err", err, 1);
        RESET = 1'b1;
        wait_clk(SS + 4);
        chk("tr_err", err, 0);
        chk("tr_inflight", {bus_req, busy}, 2'b11);
        RESET = 1'b0;
        wait_clk(SS + 3);
        serve(0, 32'h0, hi);
        chk("tr_done", {bus_req, busy, err}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
